// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter:
// FSM states, owner encoding and default bus widths.
package cpu_mem_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Counter width able to hold TIMEOUT-1; at least one bit so a disabled timeout still elaborates.
   function automatic int cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the arbiter. Handshake: mem_req is a one-cycle issue
// strobe with we/addr/wdata stable until mem_ack; mem_ack is a one-cycle
// completion strobe qualifying mem_rdata. No backpressure on either strobe.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles without an ack; expired_o flags the last allowed cycle.
// TIMEOUT of 0 disables expiry.
module mem_timeout_counter
   import cpu_mem_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency memory between the fetch port and the MEM-stage
// load/store port; one access in flight, data port wins ties.
module unified_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_if_o,
   output logic              stall_mem_o,
   output logic              err_o,
   output state_e            dbg_state_o
);

   unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   state_e            state_q;
   owner_e            owner_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_data_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_ready_q;
   logic              d_ready_q;
   logic              err_q;

   logic              grant_d;
   owner_e            owner_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              timeout_hit;

   // In RESP only the non-owner may be granted: the owner still holds its
   // request during its ready pulse and must not be served twice.
   always_comb begin
      grant_d = 1'b0;
      owner_d = OWN_D;
      unique case (state_q)
         IDLE: begin
            if (d_req_i) begin
               grant_d = 1'b1;
               owner_d = OWN_D;
            end else if (if_req_i) begin
               grant_d = 1'b1;
               owner_d = OWN_IF;
            end
         end
         RESP: begin
            if ((owner_q == OWN_IF) && d_req_i) begin
               grant_d = 1'b1;
               owner_d = OWN_D;
            end else if ((owner_q == OWN_D) && if_req_i) begin
               grant_d = 1'b1;
               owner_d = OWN_IF;
            end
         end
         default: ;
      endcase
   end

   assign we_d    = (owner_d == OWN_D) ? d_we_i    : 1'b0;
   assign addr_d  = (owner_d == OWN_D) ? d_addr_i  : if_addr_i;
   assign wdata_d = (owner_d == OWN_D) ? d_wdata_i : '0;

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (state_q != WAIT),
      .enable_i  ((state_q == WAIT) && !mem_bus.mem_ack),
      .expired_o (timeout_hit)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_data_q   <= '0;
         d_rdata_q   <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_req_q  <= 1'b0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         unique case (state_q)
            IDLE, RESP: begin
               if (grant_d) begin
                  state_q     <= ISSUE;
                  owner_q     <= owner_d;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= we_d;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               if (mem_bus.mem_ack) begin
                  state_q <= RESP;
                  if (owner_q == OWN_D) begin
                     d_ready_q <= 1'b1;
                     if (!mem_we_q) d_rdata_q <= mem_bus.mem_rdata;
                  end else begin
                     if_ready_q <= 1'b1;
                     if_data_q  <= mem_bus.mem_rdata;
                  end
               end else if (timeout_hit) begin
                  // Abort: complete toward the requester with zero data so the pipeline unfreezes.
                  state_q <= RESP;
                  err_q   <= 1'b1;
                  if (owner_q == OWN_D) begin
                     d_ready_q <= 1'b1;
                     d_rdata_q <= '0;
                  end else begin
                     if_ready_q <= 1'b1;
                     if_data_q  <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_bus.mem_req   = mem_req_q;
   assign mem_bus.mem_we    = mem_we_q;
   assign mem_bus.mem_addr  = mem_addr_q;
   assign mem_bus.mem_wdata = mem_wdata_q;
   assign mem_bus.mem_rdata = mem_rdata_i;
   assign mem_bus.mem_ack   = mem_ack_i;

   assign mem_req_o   = mem_bus.mem_req;
   assign mem_we_o    = mem_bus.mem_we;
   assign mem_addr_o  = mem_bus.mem_addr;
   assign mem_wdata_o = mem_bus.mem_wdata;

   assign if_data_o   = if_data_q;
   assign if_ready_o  = if_ready_q;
   assign d_rdata_o   = d_rdata_q;
   assign d_ready_o   = d_ready_q;
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

   assign stall_if_o  = if_req_i & ~if_ready_q;
   assign stall_mem_o = d_req_i & ~d_ready_q;

endmodule
